// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the forwarding scoreboard.
//   stage_rec_t : one in-flight pipeline record {valid, regwrite, is_load, rd}
//   FWD_RF      : fwd_sel code meaning "read the register file"
//   fwd_sel_w() : width of one fwd_sel field for a given stage count
// ---------------------------------------------------------------------------
package cpu_pkg;

    // Records carry rd at a fixed maximum width so the struct can be shared.
    // Narrower register addresses are zero-extended on entry.
    localparam int RD_MAX_W = 8;

    // fwd_sel encoding: 0 selects the register file, k selects stage k.
    localparam int FWD_RF  = 0;
    localparam int FWD_EX  = 1;
    localparam int FWD_MEM = 2;
    localparam int FWD_WB  = 3;

    typedef struct packed {
        logic                valid;
        logic                regwrite;
        logic                is_load;
        logic [RD_MAX_W-1:0] rd;
    } stage_rec_t;

    function automatic int fwd_sel_w(input int num_stages);
        return (num_stages < 1) ? 1 : $clog2(num_stages + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// ---------------------------------------------------------------------------
// fwd_match
// Finds the youngest in-flight stage that writes one source operand and
// reports whether that result is not yet forwardable.
// Ports:
//   src_addr : source register address in ID
//   src_used : operand is actually read
//   stages   : tracked records, index 0 = stage 1 (youngest)
//   sel      : 0 = register file, k = forward from stage k
//   hazard   : youngest match is not yet ready -> ID must stall
// ---------------------------------------------------------------------------
module fwd_match
    import cpu_pkg::*;
#(
    parameter int NUM_STAGES       = 3,
    parameter int REG_ADDR_W       = 5,
    parameter int ALU_READY_STAGE  = 2,
    parameter int LOAD_READY_STAGE = 3,
    parameter int SEL_W            = 2
) (
    input  logic [REG_ADDR_W-1:0]        src_addr,
    input  logic                         src_used,
    input  stage_rec_t [NUM_STAGES-1:0]  stages,
    output logic [SEL_W-1:0]             sel,
    output logic                         hazard
);

    // Walk from oldest to youngest so the youngest match overwrites older
    // ones; only that youngest match decides readiness. A record with rd=0
    // never matches, which also keeps x0 reads on the register file.
    always_comb begin
        sel    = SEL_W'(FWD_RF);
        hazard = 1'b0;
        for (int k = NUM_STAGES; k >= 1; k--) begin
            if (src_used &&
                stages[k-1].valid &&
                stages[k-1].regwrite &&
                (stages[k-1].rd != '0) &&
                (stages[k-1].rd == RD_MAX_W'(src_addr))) begin
                sel    = SEL_W'(k);
                hazard = stages[k-1].is_load ? (k < LOAD_READY_STAGE)
                                             : (k < ALU_READY_STAGE);
            end
        end
    end

endmodule

// File: rtl/forwarding_scoreboard.sv
// ---------------------------------------------------------------------------
// forwarding_scoreboard
// Tracks instructions issued past ID through NUM_STAGES stages and, for each
// ID source operand, chooses a forwarding source or requests a stall.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   issue_valid     : ID instruction wants to issue
//   issue_regwrite  : it writes a register
//   issue_is_load   : it is a load
//   issue_rd        : its destination register
//   src_addr        : NUM_SRC packed source addresses (source i at i*REG_ADDR_W)
//   src_used        : per-source "operand is read"
//   flush           : discard the ID instruction this cycle
//   hold            : freeze all tracked stages and the stall counter
//   fwd_sel         : NUM_SRC packed select fields, 0 = register file
//   stall           : ID must not issue this cycle
//   stall_count     : saturating count of hazard-stall cycles
// ---------------------------------------------------------------------------
module forwarding_scoreboard
    import cpu_pkg::*;
#(
    parameter int NUM_SRC          = 2,
    parameter int NUM_STAGES       = 3,
    parameter int REG_ADDR_W       = 5,
    parameter int ALU_READY_STAGE  = 2,
    parameter int LOAD_READY_STAGE = 3,
    parameter int CNT_W            = 16
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        issue_valid,
    input  logic                                        issue_regwrite,
    input  logic                                        issue_is_load,
    input  logic [REG_ADDR_W-1:0]                       issue_rd,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]               src_addr,
    input  logic [NUM_SRC-1:0]                          src_used,
    input  logic                                        flush,
    input  logic                                        hold,
    output logic [NUM_SRC*fwd_sel_w(NUM_STAGES)-1:0]    fwd_sel,
    output logic                                        stall,
    output logic [CNT_W-1:0]                            stall_count
);

    localparam int SEL_W = fwd_sel_w(NUM_STAGES);

    stage_rec_t [NUM_STAGES-1:0] stages;
    stage_rec_t                  issue_rec;
    logic [NUM_SRC-1:0]          hazard;
    logic                        issue_fire;

    // One matcher per source operand, all looking at the same stage records.
    // The issuing instruction is not in the records yet, so it can never
    // match its own destination.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_match #(
            .NUM_STAGES       (NUM_STAGES),
            .REG_ADDR_W       (REG_ADDR_W),
            .ALU_READY_STAGE  (ALU_READY_STAGE),
            .LOAD_READY_STAGE (LOAD_READY_STAGE),
            .SEL_W            (SEL_W)
        ) u_match (
            .src_addr (src_addr[i*REG_ADDR_W +: REG_ADDR_W]),
            .src_used (src_used[i]),
            .stages   (stages),
            .sel      (fwd_sel[i*SEL_W +: SEL_W]),
            .hazard   (hazard[i])
        );
    end

    // Stall only matters for a live ID instruction; hold does not mask it,
    // so a hazard stays visible while the pipeline is frozen.
    always_comb begin
        stall      = issue_valid && !flush && (|hazard);
        issue_fire = issue_valid && !flush && !stall;
        issue_rec          = '0;
        issue_rec.valid    = 1'b1;
        issue_rec.regwrite = issue_regwrite;
        issue_rec.is_load  = issue_is_load;
        issue_rec.rd       = RD_MAX_W'(issue_rd);
    end

    // Reset wins over hold. When not held, every record advances one stage;
    // stage 1 takes the issuing instruction or a bubble. The counter only
    // advances on cycles that actually insert a stall bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stages      <= '0;
            stall_count <= '0;
        end else if (!hold) begin
            stages[0] <= issue_fire ? issue_rec : '0;
            for (int k = 1; k < NUM_STAGES; k++) begin
                stages[k] <= stages[k-1];
            end
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_forwarding_scoreboard
// Directed hazard scenarios plus randomized traffic against a behavioural
// model that keeps the in-flight instruction history as plain arrays.
// ---------------------------------------------------------------------------
module tb_forwarding_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic        issue_regwrite;
    logic        issue_is_load;
    logic [4:0]  issue_rd;
    logic [9:0]  src_addr;
    logic [1:0]  src_used;
    logic        flush;
    logic        hold;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic [15:0] stall_count;

    int total  = 0;
    int passed = 0;

    // Model state: slot 1 is the youngest in-flight instruction.
    bit m_valid [1:3];
    bit m_wr    [1:3];
    bit m_ld    [1:3];
    int m_rd    [1:3];
    int m_cnt;

    forwarding_scoreboard dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_valid    (issue_valid),
        .issue_regwrite (issue_regwrite),
        .issue_is_load  (issue_is_load),
        .issue_rd       (issue_rd),
        .src_addr       (src_addr),
        .src_used       (src_used),
        .flush          (flush),
        .hold           (hold),
        .fwd_sel        (fwd_sel),
        .stall          (stall),
        .stall_count    (stall_count)
    );

    always #5 clk = ~clk;

    // Youngest writer of source i, 0 when the register file supplies it.
    function automatic int model_sel(input int i);
        int addr;
        addr = int'(src_addr[i*5 +: 5]);
        if (!src_used[i] || addr == 0) return 0;
        for (int k = 1; k <= 3; k++) begin
            if (m_valid[k] && m_wr[k] && m_rd[k] == addr) return k;
        end
        return 0;
    endfunction

    // A result becomes usable at stage 2 (ALU) or stage 3 (load).
    function automatic bit model_stall();
        int k;
        int ready_at;
        if (!issue_valid || flush) return 1'b0;
        for (int i = 0; i < 2; i++) begin
            k = model_sel(i);
            if (k != 0) begin
                ready_at = m_ld[k] ? 3 : 2;
                if (k < ready_at) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_update();
        bit st;
        if (!rst_n) begin
            for (int k = 1; k <= 3; k++) m_valid[k] = 1'b0;
            m_cnt = 0;
        end else if (!hold) begin
            st = model_stall();
            for (int k = 3; k >= 2; k--) begin
                m_valid[k] = m_valid[k-1];
                m_wr[k]    = m_wr[k-1];
                m_ld[k]    = m_ld[k-1];
                m_rd[k]    = m_rd[k-1];
            end
            m_valid[1] = issue_valid && !st && !flush;
            m_wr[1]    = issue_regwrite;
            m_ld[1]    = issue_is_load;
            m_rd[1]    = int'(issue_rd);
            if (st && m_cnt < 65535) m_cnt++;
        end
    endtask

    task automatic drive(input bit v, input bit wr, input bit ld, input int rd,
                         input int s0, input int s1, input bit [1:0] used,
                         input bit fl = 1'b0, input bit hd = 1'b0);
        issue_valid    = v;
        issue_regwrite = wr;
        issue_is_load  = ld;
        issue_rd       = 5'(rd);
        src_addr       = {5'(s1), 5'(s0)};
        src_used       = used;
        flush          = fl;
        hold           = hd;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 2'b00);
        advance();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        drive(1, 1, 1, 3, 0, 0, 2'b00);
        advance();
        apply_reset();
        drive(1, 1, 0, 4, 3, 3, 2'b11);
        total++; if (stall !== 1'b0) $display("[TB] FAIL reset_stall: got %0b want 0", stall); else passed++;
        total++; if (fwd_sel !== 4'b0000) $display("[TB] FAIL reset_fwd: got %b want 0000", fwd_sel); else passed++;
        total++; if (stall_count !== 16'd0) $display("[TB] FAIL reset_count: got %0d want 0", stall_count); else passed++;
        advance();
    endtask

    task automatic test_alu_hazard();
        apply_reset();
        drive(1, 1, 0, 5, 0, 0, 2'b00);
        advance();
        drive(1, 1, 0, 8, 5, 1, 2'b01);
        total++; if (stall !== 1'b1) $display("[TB] FAIL alu_stall: got %0b want 1", stall); else passed++;
        total++; if (fwd_sel !== 4'b0001) $display("[TB] FAIL alu_fwd_ex: got %b want 0001", fwd_sel); else passed++;
        advance();
        total++; if (stall !== 1'b0) $display("[TB] FAIL alu_release: got %0b want 0", stall); else passed++;
        total++; if (fwd_sel !== 4'b0010) $display("[TB] FAIL alu_fwd_mem: got %b want 0010", fwd_sel); else passed++;
        total++; if (stall_count !== 16'd1) $display("[TB] FAIL alu_count: got %0d want 1", stall_count); else passed++;
        advance();
    endtask

    task automatic test_load_hazard();
        apply_reset();
        drive(1, 1, 1, 7, 0, 0, 2'b00);
        advance();
        drive(1, 1, 0, 8, 7, 0, 2'b01);
        total++; if (stall !== 1'b1) $display("[TB] FAIL load_stall1: got %0b want 1", stall); else passed++;
        advance();
        total++; if (stall !== 1'b1) $display("[TB] FAIL load_stall2: got %0b want 1", stall); else passed++;
        total++; if (stall_count !== 16'd1) $display("[TB] FAIL load_count1: got %0d want 1", stall_count); else passed++;
        advance();
        total++; if (stall !== 1'b0) $display("[TB] FAIL load_release: got %0b want 0", stall); else passed++;
        total++; if (fwd_sel !== 4'b0011) $display("[TB] FAIL load_fwd_wb: got %b want 0011", fwd_sel); else passed++;
        total++; if (stall_count !== 16'd2) $display("[TB] FAIL load_count2: got %0d want 2", stall_count); else passed++;
        advance();
    endtask

    task automatic test_youngest();
        apply_reset();
        drive(1, 1, 0, 6, 0, 0, 2'b00);
        advance();
        drive(1, 1, 0, 6, 0, 0, 2'b00);
        advance();
        drive(0, 0, 0, 0, 0, 0, 2'b00);
        advance();
        drive(1, 1, 0, 9, 6, 6, 2'b01);
        total++; if (stall !== 1'b0) $display("[TB] FAIL young_stall: got %0b want 0", stall); else passed++;
        total++; if (fwd_sel !== 4'b0010) $display("[TB] FAIL young_fwd_unused: got %b want 0010", fwd_sel); else passed++;
        drive(1, 1, 0, 9, 6, 6, 2'b11);
        total++; if (fwd_sel !== 4'b1010) $display("[TB] FAIL young_fwd_both: got %b want 1010", fwd_sel); else passed++;
        advance();
    endtask

    task automatic test_x0_and_self();
        apply_reset();
        drive(1, 1, 0, 0, 0, 0, 2'b00);
        advance();
        drive(0, 0, 0, 0, 0, 0, 2'b00);
        advance();
        drive(1, 1, 0, 4, 0, 0, 2'b11);
        total++; if (stall !== 1'b0) $display("[TB] FAIL x0_stall: got %0b want 0", stall); else passed++;
        total++; if (fwd_sel !== 4'b0000) $display("[TB] FAIL x0_fwd: got %b want 0000", fwd_sel); else passed++;
        drive(1, 1, 1, 9, 9, 9, 2'b11);
        total++; if (stall !== 1'b0) $display("[TB] FAIL self_stall: got %0b want 0", stall); else passed++;
        total++; if (fwd_sel !== 4'b0000) $display("[TB] FAIL self_fwd: got %b want 0000", fwd_sel); else passed++;
        advance();
    endtask

    task automatic test_hold();
        apply_reset();
        drive(1, 1, 1, 7, 0, 0, 2'b00);
        advance();
        drive(1, 1, 0, 8, 0, 7, 2'b10);
        advance();
        for (int c = 0; c < 3; c++) begin
            drive(1, 1, 0, 8, 0, 7, 2'b10, 1'b0, 1'b1);
            total++; if (stall !== 1'b1) $display("[TB] FAIL hold_stall[%0d]: got %0b want 1", c, stall); else passed++;
            total++; if (fwd_sel !== 4'b1000) $display("[TB] FAIL hold_fwd[%0d]: got %b want 1000", c, fwd_sel); else passed++;
            total++; if (stall_count !== 16'd1) $display("[TB] FAIL hold_count[%0d]: got %0d want 1", c, stall_count); else passed++;
            advance();
        end
        drive(1, 1, 0, 8, 0, 7, 2'b10);
        total++; if (stall !== 1'b1) $display("[TB] FAIL hold_resume_stall: got %0b want 1", stall); else passed++;
        advance();
        total++; if (stall !== 1'b0) $display("[TB] FAIL hold_release: got %0b want 0", stall); else passed++;
        total++; if (fwd_sel !== 4'b1100) $display("[TB] FAIL hold_fwd_wb: got %b want 1100", fwd_sel); else passed++;
        total++; if (stall_count !== 16'd2) $display("[TB] FAIL hold_count_end: got %0d want 2", stall_count); else passed++;
        advance();
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        drive(1, 1, 0, 5, 0, 0, 2'b00);
        advance();
        drive(1, 1, 0, 8, 5, 0, 2'b01);
        advance();
        drive(1, 1, 1, 7, 5, 0, 2'b01);
        advance();
        drive(1, 1, 0, 8, 7, 0, 2'b01);
        total++; if (stall !== 1'b1 || stall_count !== 16'd1) $display("[TB] FAIL mid_pre: stall=%0b count=%0d want 1/1", stall, stall_count); else passed++;
        rst_n = 1'b0;
        advance();
        rst_n = 1'b1;
        drive(1, 1, 0, 8, 7, 0, 2'b01);
        total++; if (stall !== 1'b0) $display("[TB] FAIL mid_stall: got %0b want 0", stall); else passed++;
        total++; if (fwd_sel !== 4'b0000) $display("[TB] FAIL mid_fwd: got %b want 0000", fwd_sel); else passed++;
        total++; if (stall_count !== 16'd0) $display("[TB] FAIL mid_count: got %0d want 0", stall_count); else passed++;
        advance();
    endtask

    task automatic test_random();
        int exp_sel;
        bit exp_stall;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  2'($urandom_range(0, 3)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
            exp_stall = model_stall();
            total++; if (stall !== exp_stall) $display("[TB] FAIL rnd_stall@%0d: got %0b want %0b", n, stall, exp_stall); else passed++;
            for (int i = 0; i < 2; i++) begin
                exp_sel = model_sel(i);
                total++; if (fwd_sel[i*2 +: 2] !== 2'(exp_sel)) $display("[TB] FAIL rnd_fwd%0d@%0d: got %0d want %0d", i, n, fwd_sel[i*2 +: 2], exp_sel); else passed++;
            end
            total++; if (stall_count !== 16'(m_cnt)) $display("[TB] FAIL rnd_count@%0d: got %0d want %0d", n, stall_count, m_cnt); else passed++;
            advance();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        m_cnt = 0;
        for (int k = 1; k <= 3; k++) begin
            m_valid[k] = 1'b0;
            m_wr[k]    = 1'b0;
            m_ld[k]    = 1'b0;
            m_rd[k]    = 0;
        end
        drive(0, 0, 0, 0, 0, 0, 2'b00);
        advance();
        test_reset();
        test_alu_hazard();
        test_load_hazard();
        test_youngest();
        test_x0_and_self();
        test_hold();
        test_reset_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
